food_timer_bank: RTL and testbench
==================================

// Module: food_timer_bank
// PURPOSE
//   Parametrised bank of independent feed-dispense timers. Each channel holds a programmable
//   duration. On start it drives its active output for exactly that many enabled clock cycles,
//   then raises a one-cycle done pulse. Sits between the feeder control FSM and the
//   per-bowl dispense switches. Adds per-channel durations, abort/clear, optional retrigger
//   and done signalling on top of the single fixed-time food counter.
// PARAMETERS
//   CHANNELS      4    number of independent timer channels (1..16)
//   CNT_W         4    counter/duration width; max duration 2**CNT_W-1
//   DEFAULT_TIME  10   reset value of every duration register (must fit CNT_W)
//   RETRIGGER     0    1: start during RUN restarts count at 0; 0: start during RUN ignored
// PORTS
//   clock      in   1                 system clock, rising edge
//   reset      in   1                 asynchronous, active-low; clears all state
//   enable     in   1                 global count enable; 0 freezes all counters, outputs hold
//   start      in   CHANNELS          per-channel start request, sampled each edge
//   clear      in   CHANNELS          per-channel synchronous clear to IDLE (count_reset successor)
//   load_we    in   1                 write strobe for duration register
//   load_ch    in   $clog2(CHANNELS)  channel index for load; index >= CHANNELS ignored
//   load_time  in   CNT_W             duration value written
//   active     out  CHANNELS          1 while channel is in RUN (dispense switch)
//   done       out  CHANNELS          one-cycle pulse on natural completion only
//   busy       out  1                 OR of active
//   count_out  out  CHANNELS*CNT_W    per-channel count, channel i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, count=0, active=0, done=0, busy=0, dur=DEFAULT_TIME.
//   All outputs are registered. busy is combinational OR of registered active.
//   Per-channel states: IDLE, RUN, DONE.
//     IDLE: start=1 and latched dur!=0 -> RUN, count=0, active=1 after the same edge.
//           start=1 and dur==0 -> done pulse next cycle, stay IDLE, active never rises.
//     RUN : each edge with enable=1: count+1. When count+1==run_dur: -> DONE, active=0, done=1.
//           With enable held high, active is high for exactly run_dur cycles.
//           start=1 & RETRIGGER=1 -> count=0, run_dur re-latched. start=1 & RETRIGGER=0 -> ignored.
//     DONE: count holds run_dur, active=0. done is high for the first DONE cycle only.
//           start -> RUN as from IDLE. clear -> IDLE.
//   clear[i]=1: next edge state=IDLE, count=0, active=0. No done pulse, including when
//     completion coincides with clear.
//   Priority per channel per edge: reset > clear > start > count.
//   start and done are not gated by enable. Only counting is gated.
//   Duration: load_we writes dur[load_ch] at the edge. On start, dur is copied to run_dur.
//     A load during RUN affects the next start only. Load and start on the same edge for the
//     same channel: start uses the OLD dur.
//   Width: count never wraps. It saturates at run_dur by construction. run_dur <= 2**CNT_W-1.
//   enable=0 mid-RUN: count and active freeze. Counting resumes with no lost or extra cycle.
//   Channels are fully independent. Simultaneous starts and completions on any subset are legal.
// STRUCTURE
//   food_timer_pkg.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//   Sub-module food_timer_channel (one FSM, count, run_dur, active/done regs), instantiated
//   CHANNELS times in a generate loop. The top holds the dur[] register file, load decode,
//   busy OR and count_out packing.
// TESTING (clock period 4 ns, defaults unless stated)
//   1 Reset then start[0] pulse, enable=1: active[0] high exactly 10 cycles, done[0] 1 cycle
//     after fall, count_out[3:0]=10 in DONE.
//   2 load ch2=3, start ch2 and ch1 together: active[2] 3 cycles, active[1] 10 cycles,
//     busy high 10 cycles.
//   3 enable low for 5 cycles at count=4 on ch0: active[0] stays high.
//     Total active = 15 cycles, done at count 10.
//   4 clear[0] at count=6: active drops next edge, count=0, no done. Clear on completion
//     edge: no done.
//   5 RETRIGGER=1, start again at count=7: count returns 0, active total 17 cycles.
//     RETRIGGER=0: start ignored, 10 cycles.
//   6 load ch3=0 then start[3]: done[3] pulses, active[3] stays 0. Async reset mid-RUN:
//     all outputs 0 immediately.

Source files
------------

// File: rtl/food_timer_bank_pkg.sv
// -----------------------------------------------------------------------------
// food_timer_bank_pkg
//   Shared definitions for the feed-dispense timer bank: the per-channel state
//   encoding and a helper that sizes the channel-select bus of the load port.
//   No ports; imported by food_timer_bank and food_timer_bank_channel.
// -----------------------------------------------------------------------------
package food_timer_bank_pkg;

   // Per-channel timer state. The encodings are fixed so that a state captured
   // on a debug probe maps directly onto the feeder documentation.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } timerState_t;

   // Width of a channel index bus. A single-channel bank still gets a 1-bit
   // index so that the load port never collapses to a zero-width vector.
   function automatic int loadChWidth(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/food_timer_bank_channel.sv
// -----------------------------------------------------------------------------
// food_timer_bank_channel
//   One independent dispense timer. On start it latches the duration offered by
//   the bank's duration register, holds o_active high for that many enabled
//   cycles, then raises o_done for one cycle and rests in DONE with the count
//   parked at the run duration.
//
//   Ports
//     clock      in   1       system clock, rising edge
//     reset      in   1       asynchronous, active-low
//     i_enable   in   1       count enable; only counting is gated
//     i_start    in   1       start request
//     i_clear    in   1       synchronous return to IDLE, no done pulse
//     i_dur      in   CNT_W   current duration register of this channel
//     o_count    out  CNT_W   elapsed enabled cycles of the current run
//     o_active   out  1       high while in RUN
//     o_done     out  1       one-cycle pulse on natural completion
// -----------------------------------------------------------------------------
module food_timer_bank_channel
   import food_timer_bank_pkg::*;
#(
   parameter int CNT_W     = 4,
   parameter int RETRIGGER = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_start,
   input  logic             i_clear,
   input  logic [CNT_W-1:0] i_dur,
   output logic [CNT_W-1:0] o_count,
   output logic             o_active,
   output logic             o_done
);

   timerState_t      r_state;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_runDur;
   logic             r_active;
   logic             r_done;

   logic [CNT_W-1:0] w_countNext;
   logic             w_launch;
   logic             w_durZero;
   logic             w_stateLegal;

   // A start launches a run from IDLE or DONE; while running it only
   // relaunches when the bank is built with retrigger enabled. The count
   // can never wrap: run_dur is at least 1 and the run ends as soon as the
   // incremented count reaches it.
   assign w_countNext  = r_count + 1'b1;
   assign w_launch     = i_start && ((r_state != ST_RUN) || (RETRIGGER != 0));
   assign w_durZero    = (i_dur == '0);
   assign w_stateLegal = (r_state == ST_IDLE) || (r_state == ST_RUN) ||
                         (r_state == ST_DONE);

   // Channel FSM with registered outputs. done defaults low every edge so it
   // can only ever be a single-cycle pulse. Priority is clear, then start,
   // then counting. A zero duration never enters RUN: it answers a start with
   // an immediate done pulse and stays idle, so the switch never closes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_runDur <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_clear) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_active <= 1'b0;
         end else if (w_launch) begin
            r_count  <= '0;
            r_runDur <= i_dur;
            if (w_durZero) begin
               r_state  <= ST_IDLE;
               r_active <= 1'b0;
               r_done   <= 1'b1;
            end else begin
               r_state  <= ST_RUN;
               r_active <= 1'b1;
            end
         end else if ((r_state == ST_RUN) && i_enable) begin
            r_count <= w_countNext;
            if (w_countNext == r_runDur) begin
               r_state  <= ST_DONE;
               r_active <= 1'b0;
               r_done   <= 1'b1;
            end
         end else if (!w_stateLegal) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_active <= 1'b0;
         end
      end
   end

   assign o_count  = r_count;
   assign o_active = r_active;
   assign o_done   = r_done;

endmodule

// File: rtl/food_timer_bank.sv
// -----------------------------------------------------------------------------
// food_timer_bank
//   Bank of independent feed-dispense timers sitting between the feeder control
//   FSM and the per-bowl dispense switches. Holds one programmable duration per
//   channel, a load port to rewrite them, and the per-channel timers.
//
//   Ports
//     clock      in   1                  system clock, rising edge
//     reset      in   1                  asynchronous, active-low
//     enable     in   1                  global count enable
//     start      in   CHANNELS           per-channel start request
//     clear      in   CHANNELS           per-channel synchronous clear to IDLE
//     load_we    in   1                  duration write strobe
//     load_ch    in   clog2(CHANNELS)    channel written; out-of-range ignored
//     load_time  in   CNT_W              duration value written
//     active     out  CHANNELS           high while channel runs
//     done       out  CHANNELS           one-cycle completion pulse
//     busy       out  1                  any channel active
//     count_out  out  CHANNELS*CNT_W     channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module food_timer_bank
   import food_timer_bank_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int CNT_W        = 4,
   parameter int DEFAULT_TIME = 10,
   parameter int RETRIGGER    = 0
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   input  logic [CHANNELS-1:0]             start,
   input  logic [CHANNELS-1:0]             clear,
   input  logic                            load_we,
   input  logic [loadChWidth(CHANNELS)-1:0] load_ch,
   input  logic [CNT_W-1:0]                load_time,
   output logic [CHANNELS-1:0]             active,
   output logic [CHANNELS-1:0]             done,
   output logic                            busy,
   output logic [CHANNELS*CNT_W-1:0]       count_out
);

   logic [CNT_W-1:0] r_dur [CHANNELS];
   logic             w_loadValid;

   // Non-power-of-two banks leave some index codes unused; writes to them
   // are dropped instead of aliasing onto a real channel.
   assign w_loadValid = load_we && (int'(load_ch) < CHANNELS);

   // Duration register file. A channel copies its entry only at the moment
   // it starts, so a write landing on the same edge as that channel's start
   // is seen by the following start, never by the current one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_dur[i] <= CNT_W'(DEFAULT_TIME);
         end
      end else if (w_loadValid) begin
         r_dur[load_ch] <= load_time;
      end
   end

   // One timer per channel; the bank adds nothing between a channel and its
   // outputs apart from packing the counts into one bus.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [CNT_W-1:0] w_count;

      food_timer_bank_channel #(
         .CNT_W     (CNT_W),
         .RETRIGGER (RETRIGGER)
      ) u_channel (
         .clock    (clock),
         .reset    (reset),
         .i_enable (enable),
         .i_start  (start[g]),
         .i_clear  (clear[g]),
         .i_dur    (r_dur[g]),
         .o_count  (w_count),
         .o_active (active[g]),
         .o_done   (done[g])
      );

      assign count_out[g*CNT_W +: CNT_W] = w_count;
   end

   assign busy = |active;

endmodule

// File: tb/tb_food_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_food_timer_bank
//   Directed bench for the timer bank with default parameters. dutA is built
//   without retrigger, dutB with retrigger; both see identical inputs so the
//   retrigger difference shows up side by side.
// -----------------------------------------------------------------------------
module tb_food_timer_bank;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [3:0]  start;
   logic [3:0]  clear;
   logic        load_we;
   logic [1:0]  load_ch;
   logic [3:0]  load_time;

   logic [3:0]  activeA, doneA, activeB, doneB;
   logic        busyA, busyB;
   logic [15:0] countA, countB;

   int errors = 0;
   int checks = 0;

   food_timer_bank #(.CHANNELS(4), .CNT_W(4), .DEFAULT_TIME(10), .RETRIGGER(0)) dutA (
      .clock(clock), .reset(reset), .enable(enable), .start(start), .clear(clear),
      .load_we(load_we), .load_ch(load_ch), .load_time(load_time),
      .active(activeA), .done(doneA), .busy(busyA), .count_out(countA));

   food_timer_bank #(.CHANNELS(4), .CNT_W(4), .DEFAULT_TIME(10), .RETRIGGER(1)) dutB (
      .clock(clock), .reset(reset), .enable(enable), .start(start), .clear(clear),
      .load_we(load_we), .load_ch(load_ch), .load_time(load_time),
      .active(activeB), .done(doneB), .busy(busyB), .count_out(countB));

   // 4 ns clock, rising edges at 2, 6, 10, ...
   initial clock = 1'b0;
   always #2 clock = ~clock;

   // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
   task automatic stepClock();
      @(posedge clock);
      #1;
   endtask

   // Present start/clear for exactly one edge.
   task automatic applyStimulus(input logic [3:0] s, input logic [3:0] c);
      start = s;
      clear = c;
      stepClock();
      start = '0;
      clear = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int actA, actB, act1, act2, busyCnt, guard, doneSeen;
      bit retrigDone;

      reset = 1'b0; enable = 1'b1; start = '0; clear = '0;
      load_we = 1'b0; load_ch = '0; load_time = '0;
      stepClock();
      stepClock();

      // Reset state
      checkOutput("rst_active", {28'd0, activeA}, 32'd0);
      checkOutput("rst_done",   {28'd0, doneA},   32'd0);
      checkOutput("rst_busy",   {31'd0, busyA},   32'd0);
      checkOutput("rst_count",  {16'd0, countA},  32'd0);
      reset = 1'b1;
      stepClock();

      // 1: default run on ch0 lasts 10 cycles, done on the first low cycle
      applyStimulus(4'b0001, 4'b0000);
      actA = 0; guard = 0;
      while (activeA[0] && guard < 40) begin actA++; stepClock(); guard++; end
      checkOutput("t1_active_cycles", actA, 32'd10);
      checkOutput("t1_done_pulse", {31'd0, doneA[0]}, 32'd1);
      checkOutput("t1_count_done", {28'd0, countA[3:0]}, 32'd10);
      stepClock();
      checkOutput("t1_done_one_cycle", {31'd0, doneA[0]}, 32'd0);
      checkOutput("t1_count_hold", {28'd0, countA[3:0]}, 32'd10);

      // 2: ch2 loaded with 3, ch1 default, started together
      load_we = 1'b1; load_ch = 2'd2; load_time = 4'd3;
      stepClock();
      load_we = 1'b0;
      applyStimulus(4'b0110, 4'b0000);
      act1 = 0; act2 = 0; busyCnt = 0; guard = 0;
      while (busyA && guard < 40) begin
         if (activeA[1]) act1++;
         if (activeA[2]) act2++;
         busyCnt++;
         stepClock(); guard++;
      end
      checkOutput("t2_ch2_cycles", act2, 32'd3);
      checkOutput("t2_ch1_cycles", act1, 32'd10);
      checkOutput("t2_busy_cycles", busyCnt, 32'd10);

      // 3: enable dropped for 5 cycles while ch0 shows count 4
      applyStimulus(4'b0001, 4'b0000);
      actA = 0; guard = 0;
      while (activeA[0] && countA[3:0] != 4'd4 && guard < 40) begin actA++; stepClock(); guard++; end
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (activeA[0]) actA++;
         stepClock();
      end
      checkOutput("t3_frozen_active", {31'd0, activeA[0]}, 32'd1);
      checkOutput("t3_frozen_count", {28'd0, countA[3:0]}, 32'd4);
      enable = 1'b1;
      guard = 0;
      while (activeA[0] && guard < 40) begin actA++; stepClock(); guard++; end
      checkOutput("t3_active_cycles", actA, 32'd15);
      checkOutput("t3_done_count", {27'd0, doneA[0], countA[3:0]}, {27'd0, 1'b1, 4'd10});

      // 4a: clear at count 6 drops active, zeroes count, no done afterwards
      applyStimulus(4'b0001, 4'b0000);
      guard = 0;
      while (countA[3:0] != 4'd6 && guard < 40) begin stepClock(); guard++; end
      applyStimulus(4'b0000, 4'b0001);
      checkOutput("t4_clear_active", {31'd0, activeA[0]}, 32'd0);
      checkOutput("t4_clear_count", {28'd0, countA[3:0]}, 32'd0);
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         if (doneA[0]) doneSeen++;
         stepClock();
      end
      checkOutput("t4_clear_no_done", doneSeen, 32'd0);

      // 4b: clear on the completion edge suppresses done
      applyStimulus(4'b0001, 4'b0000);
      guard = 0;
      while (countA[3:0] != 4'd9 && guard < 40) begin stepClock(); guard++; end
      applyStimulus(4'b0000, 4'b0001);
      checkOutput("t4_complete_clear", {26'd0, doneA[0], activeA[0], countA[3:0]}, 32'd0);

      // 5: second start sampled on the edge that would take count to 7.
      //    No retrigger: ignored, 10 cycles. Retrigger: 7 + 10 = 17 cycles.
      applyStimulus(4'b0001, 4'b0000);
      actA = 0; actB = 0; guard = 0; retrigDone = 1'b0;
      while ((activeA[0] || activeB[0]) && guard < 60) begin
         if (activeA[0]) actA++;
         if (activeB[0]) actB++;
         if (countB[3:0] == 4'd6 && !retrigDone) begin
            start = 4'b0001;
            retrigDone = 1'b1;
         end else begin
            start = 4'b0000;
         end
         stepClock(); guard++;
      end
      start = '0;
      checkOutput("t5_noretrig_cycles", actA, 32'd10);
      checkOutput("t5_retrig_cycles", actB, 32'd17);

      // Load and start on one edge: the run uses the old duration (10),
      // the next start picks up the new one (2)
      load_we = 1'b1; load_ch = 2'd1; load_time = 4'd2;
      applyStimulus(4'b0010, 4'b0000);
      load_we = 1'b0;
      act1 = 0; guard = 0;
      while (activeA[1] && guard < 40) begin act1++; stepClock(); guard++; end
      checkOutput("ld_same_edge_old", act1, 32'd10);
      applyStimulus(4'b0010, 4'b0000);
      act1 = 0; guard = 0;
      while (activeA[1] && guard < 40) begin act1++; stepClock(); guard++; end
      checkOutput("ld_next_start_new", act1, 32'd2);

      // 6a: zero duration gives a done pulse without ever activating
      load_we = 1'b1; load_ch = 2'd3; load_time = 4'd0;
      stepClock();
      load_we = 1'b0;
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("t6_zero_done", {31'd0, doneA[3]}, 32'd1);
      checkOutput("t6_zero_active", {31'd0, activeA[3]}, 32'd0);
      stepClock();
      checkOutput("t6_zero_done_end", {30'd0, doneA[3], activeA[3]}, 32'd0);

      // 6b: asynchronous reset mid-run clears outputs without waiting for an edge
      applyStimulus(4'b0001, 4'b0000);
      stepClock();
      reset = 1'b0;
      #1;
      checkOutput("t6_async_active", {28'd0, activeA}, 32'd0);
      checkOutput("t6_async_busy_done", {27'd0, busyA, doneA}, 32'd0);
      checkOutput("t6_async_count", {16'd0, countA}, 32'd0);
      reset = 1'b1;
      stepClock();

      // Reset restored ch3 to the default duration, so it runs again
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("t6_dur_restored", {31'd0, activeA[3]}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
